// File: rtl/log_sink_checker.sv
// Avalon-ST video sink: decodes control packets, checks video packet size against them and
// reports frame statistics. Define SINK_BACKPRESSURE_EN for LFSR-driven din_ready.
module log_sink_checker #(
    parameter logic [23:0] FRONT_COLOR = 24'hffffff,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic        clock,
    input  logic        reset,
    output logic        din_ready,
    input  logic        din_valid,
    input  logic [23:0] din_data,
    input  logic        din_sop,
    input  logic        din_eop,
    input  logic [1:0]  din_empty,
    input  logic        err_clear,
    output logic [15:0] frame_width,
    output logic [15:0] frame_height,
    output logic        frame_done,
    output logic [15:0] frame_cnt,
    output logic [31:0] fg_pixel_cnt,
    output logic [3:0]  err_flags
);

    typedef enum logic [1:0] {StIdle, StCtrl, StVideo, StSkip} state_e;

    state_e      state_q, state_d;
    logic        ready_q, ready_d, ready_prev_q;
    logic        ctrl_valid_q, ctrl_valid_d;
    logic [1:0]  beat_idx_q, beat_idx_d;
    logic [15:0] shadow_w_q, shadow_w_d, shadow_h_q, shadow_h_d;
    logic [15:0] width_q, width_d, height_q, height_d;
    logic [15:0] dot_q, dot_d, line_q, line_d;
    logic [31:0] fg_acc_q, fg_acc_d;
    logic        pkt_err_q, pkt_err_d;
    logic        done_q, done_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [31:0] fg_cnt_q, fg_cnt_d;
    logic [3:0]  err_q, err_set;
    logic        accept, at_last_pixel, unused_bits;

    // Ready latency 1: a beat counts only if din_ready was high the cycle before.
    assign accept = din_valid & ready_prev_q;
    assign at_last_pixel = (width_q != 16'd0) && (height_q != 16'd0) &&
                           (dot_q == width_q - 16'd1) && (line_q == height_q - 16'd1);

`ifdef SINK_BACKPRESSURE_EN
    logic [15:0] lfsr_q;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end
    assign ready_d     = lfsr_q[0];
    assign unused_bits = ^din_empty;
`else
    assign ready_d     = 1'b1;
    assign unused_bits = ^{din_empty, LFSR_SEED};
`endif

    always_comb begin
        state_d      = state_q;
        ctrl_valid_d = ctrl_valid_q;
        beat_idx_d   = beat_idx_q;
        shadow_w_d   = shadow_w_q;
        shadow_h_d   = shadow_h_q;
        width_d      = width_q;
        height_d     = height_q;
        dot_d        = dot_q;
        line_d       = line_q;
        fg_acc_d     = fg_acc_q;
        pkt_err_d    = pkt_err_q;
        done_d       = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        fg_cnt_d     = fg_cnt_q;
        err_set      = 4'b0000;

        if (din_valid && !ready_prev_q) err_set[1] = 1'b1;

        if (accept && din_sop) begin
            if (state_q != StIdle) err_set[2] = 1'b1;
            state_d = StIdle;
            case (din_data[3:0])
                4'hF: begin
                    ctrl_valid_d = 1'b0;
                    beat_idx_d   = 2'd0;
                    if (din_eop) err_set[0] = 1'b1;
                    else state_d = StCtrl;
                end
                4'h0: begin
                    // Each video packet consumes the control packet that preceded it.
                    ctrl_valid_d = 1'b0;
                    dot_d        = 16'd0;
                    line_d       = 16'd0;
                    fg_acc_d     = 32'd0;
                    pkt_err_d    = !ctrl_valid_q;
                    if (!ctrl_valid_q) err_set[3] = 1'b1;
                    if (din_eop) begin
                        done_d   = 1'b1;
                        fg_cnt_d = 32'd0;
                        if (width_q != 16'd0 && height_q != 16'd0) err_set[1] = 1'b1;
                        else if (ctrl_valid_q) frame_cnt_d = frame_cnt_q + 16'd1;
                    end else begin
                        state_d = StVideo;
                    end
                end
                default: if (!din_eop) state_d = StSkip;
            endcase
        end else if (accept) begin
            case (state_q)
                StCtrl: begin
                    case (beat_idx_q)
                        2'd0: shadow_w_d[15:4] = {din_data[3:0], din_data[11:8], din_data[19:16]};
                        2'd1: begin
                            shadow_w_d[3:0]  = din_data[3:0];
                            shadow_h_d[15:8] = {din_data[11:8], din_data[19:16]};
                        end
                        2'd2: shadow_h_d[7:0] = {din_data[3:0], din_data[11:8]};
                        default: ;
                    endcase
                    if (beat_idx_q != 2'd3) beat_idx_d = beat_idx_q + 2'd1;
                    if (din_eop) begin
                        state_d = StIdle;
                        if (beat_idx_q == 2'd2) begin
                            width_d      = shadow_w_d;
                            height_d     = shadow_h_d;
                            ctrl_valid_d = 1'b1;
                        end else begin
                            err_set[0] = 1'b1;
                        end
                    end
                end
                StVideo: begin
                    if (width_q == 16'd0 || height_q == 16'd0 || line_q >= height_q) begin
                        err_set[1] = 1'b1;
                    end
                    if (dot_q == width_q - 16'd1) begin
                        dot_d = 16'd0;
                        if (line_q != 16'hffff) line_d = line_q + 16'd1;
                    end else begin
                        dot_d = dot_q + 16'd1;
                    end
                    if (din_data == FRONT_COLOR && fg_acc_q != 32'hffff_ffff) begin
                        fg_acc_d = fg_acc_q + 32'd1;
                    end
                    if (din_eop) begin
                        if (!at_last_pixel) err_set[1] = 1'b1;
                        state_d  = StIdle;
                        done_d   = 1'b1;
                        fg_cnt_d = fg_acc_d;
                        if (!pkt_err_q && err_set == 4'b0000) frame_cnt_d = frame_cnt_q + 16'd1;
                    end
                    if (err_set != 4'b0000) pkt_err_d = 1'b1;
                end
                StSkip: if (din_eop) state_d = StIdle;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            ready_q      <= 1'b0;
            ready_prev_q <= 1'b0;
            ctrl_valid_q <= 1'b0;
            beat_idx_q   <= 2'd0;
            shadow_w_q   <= 16'd0;
            shadow_h_q   <= 16'd0;
            width_q      <= 16'd0;
            height_q     <= 16'd0;
            dot_q        <= 16'd0;
            line_q       <= 16'd0;
            fg_acc_q     <= 32'd0;
            pkt_err_q    <= 1'b0;
            done_q       <= 1'b0;
            frame_cnt_q  <= 16'd0;
            fg_cnt_q     <= 32'd0;
            err_q        <= 4'b0000;
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            ready_prev_q <= ready_q;
            ctrl_valid_q <= ctrl_valid_d;
            beat_idx_q   <= beat_idx_d;
            shadow_w_q   <= shadow_w_d;
            shadow_h_q   <= shadow_h_d;
            width_q      <= width_d;
            height_q     <= height_d;
            dot_q        <= dot_d;
            line_q       <= line_d;
            fg_acc_q     <= fg_acc_d;
            pkt_err_q    <= pkt_err_d;
            done_q       <= done_d;
            frame_cnt_q  <= frame_cnt_d;
            fg_cnt_q     <= fg_cnt_d;
            // A new error in the clearing cycle still lands.
            err_q        <= (err_clear ? 4'b0000 : err_q) | err_set;
        end
    end

    assign din_ready    = ready_q;
    assign frame_width  = width_q;
    assign frame_height = height_q;
    assign frame_done   = done_q;
    assign frame_cnt    = frame_cnt_q;
    assign fg_pixel_cnt = fg_cnt_q;
    assign err_flags    = err_q;

endmodule

// File: tb/tb_log_sink_checker.sv
// Bench for log_sink_checker: directed protocol cases plus randomized frames compared against a
// packet-level reference model of dimensions, counts and sticky flags.
module tb_log_sink_checker;
    localparam logic [23:0] Fg = 24'hffffff;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        din_ready, din_valid, din_sop, din_eop, err_clear;
    logic [23:0] din_data;
    logic [1:0]  din_empty;
    logic [15:0] frame_width, frame_height, frame_cnt;
    logic        frame_done;
    logic [31:0] fg_pixel_cnt;
    logic [3:0]  err_flags;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    logic rdy_prev = 1'b0;

    // Reference model state
    logic [15:0] m_w = 16'd0, m_h = 16'd0, m_fcnt = 16'd0;
    logic [31:0] m_fg = 32'd0;
    logic [3:0]  m_err = 4'd0;
    bit          m_cv = 1'b0, m_open = 1'b0;
    int          m_done = 0;

    log_sink_checker dut (
        .clock        (clock),
        .reset        (reset),
        .din_ready    (din_ready),
        .din_valid    (din_valid),
        .din_data     (din_data),
        .din_sop      (din_sop),
        .din_eop      (din_eop),
        .din_empty    (din_empty),
        .err_clear    (err_clear),
        .frame_width  (frame_width),
        .frame_height (frame_height),
        .frame_done   (frame_done),
        .frame_cnt    (frame_cnt),
        .fg_pixel_cnt (fg_pixel_cnt),
        .err_flags    (err_flags)
    );

    always #5 clock = ~clock;
    always @(negedge clock) if (frame_done === 1'b1) done_seen++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // rdy_prev always holds din_ready of the cycle before the current one.
    task automatic tick();
        rdy_prev = din_ready;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        din_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send(input logic [23:0] d, input logic s, input logic e);
        int g = 0;
        din_valid = 1'b0;
        while (!rdy_prev && g < 2000) begin
            tick();
            g++;
        end
        if (!rdy_prev) check("ready_timeout", 32'(rdy_prev), 32'd1);
        din_data  = d;
        din_sop   = s;
        din_eop   = e;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        din_sop   = 1'b0;
        din_eop   = 1'b0;
    endtask

    task automatic drop_beat();
        int g = 0;
        while (rdy_prev && g < 2000) begin
            tick();
            g++;
        end
        din_data  = 24'h000001;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        m_err[1]  = 1'b1;
    endtask

    task automatic clear_err();
        err_clear = 1'b1;
        idle(1);
        err_clear = 1'b0;
        m_err     = 4'd0;
    endtask

    task automatic hdr(input logic [3:0] typ, input logic eop);
        logic [23:0] d;
        d      = 24'($urandom);
        d[3:0] = typ;
        if (m_open) m_err[2] = 1'b1;
        m_open = 1'b0;
        send(d, 1'b1, eop);
    endtask

    task automatic send_ctrl(input logic [15:0] w, input logic [15:0] h, input int nb);
        logic [23:0] d;
        hdr(4'hF, nb == 0);
        for (int i = 0; i < nb; i++) begin
            d = 24'($urandom);
            if (i == 0) begin
                d[3:0] = w[15:12]; d[11:8] = w[11:8]; d[19:16] = w[7:4];
            end else if (i == 1) begin
                d[3:0] = w[3:0]; d[11:8] = h[15:12]; d[19:16] = h[11:8];
            end else if (i == 2) begin
                d[3:0] = h[7:4]; d[11:8] = h[3:0];
            end
            send(d, 1'b0, i == nb - 1);
        end
        if (nb == 3) begin
            m_w = w; m_h = h; m_cv = 1'b1;
        end else begin
            m_err[0] = 1'b1; m_cv = 1'b0;
        end
    endtask

    // nfg < 0: random pixels; otherwise the first nfg pixels are foreground.
    task automatic send_video(input int n, input bit abandon, input int nfg);
        logic [23:0] px;
        int  fg = 0;
        int  area;
        bit  perr, bad;
        perr = !m_cv;
        if (!m_cv) m_err[3] = 1'b1;
        m_cv = 1'b0;
        hdr(4'h0, n == 0 && !abandon);
        for (int i = 0; i < n; i++) begin
            if (nfg < 0) px = ($urandom_range(0, 2) == 0) ? Fg : 24'($urandom);
            else px = (i < nfg) ? Fg : 24'h123456;
            if (px == Fg) fg++;
            send(px, 1'b0, !abandon && i == n - 1);
        end
        area = int'(m_w) * int'(m_h);
        if (abandon) begin
            if (n > area) m_err[1] = 1'b1;
            m_open = 1'b1;
        end else begin
            check("frame_done_pulse", 32'(frame_done), 32'd1);
            bad = (n != area);
            if (bad) m_err[1] = 1'b1;
            m_done++;
            m_fg = 32'(fg);
            if (!perr && !bad) m_fcnt++;
        end
    endtask

    task automatic send_skip(input logic [3:0] typ, input int n);
        hdr(typ, n == 0);
        for (int i = 0; i < n; i++) send(24'($urandom), 1'b0, i == n - 1);
    endtask

    task automatic check_all(input string tag);
        idle(1);
        check({tag, ".width"}, 32'(frame_width), 32'(m_w));
        check({tag, ".height"}, 32'(frame_height), 32'(m_h));
        check({tag, ".frame_cnt"}, 32'(frame_cnt), 32'(m_fcnt));
        check({tag, ".fg"}, fg_pixel_cnt, m_fg);
        check({tag, ".err"}, 32'(err_flags), 32'(m_err));
        check({tag, ".done_count"}, 32'(done_seen), 32'(m_done));
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".ready"}, 32'(din_ready), 32'd0);
        check({tag, ".width"}, 32'(frame_width), 32'd0);
        check({tag, ".height"}, 32'(frame_height), 32'd0);
        check({tag, ".done"}, 32'(frame_done), 32'd0);
        check({tag, ".frame_cnt"}, 32'(frame_cnt), 32'd0);
        check({tag, ".fg"}, fg_pixel_cnt, 32'd0);
        check({tag, ".err"}, 32'(err_flags), 32'd0);
    endtask

    initial begin
        din_valid = 1'b0; din_sop = 1'b0; din_eop = 1'b0; din_data = 24'd0;
        din_empty = 2'd0; err_clear = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_zero("reset");
        reset = 1'b0;
        rdy_prev = 1'b0;

        drop_beat();
`ifndef SINK_BACKPRESSURE_EN
        check("ready_after_reset", 32'(din_ready), 32'd1);
`endif
        check_all("dropped_beat");
        clear_err();

        send_ctrl(16'd40, 16'd7, 3);
        send_video(280, 1'b0, -1);
        check_all("good_40x7");

        send_ctrl(16'd4, 16'd2, 3);
        send_video(8, 1'b0, 3);
        check_all("fg_4x2");
        check("fg_4x2_value", fg_pixel_cnt, 32'd3);

        send_ctrl(16'd9, 16'd9, 2);
        check_all("short_ctrl");
        check("short_ctrl_flags", 32'(err_flags), 32'b0001);
        send_video(8, 1'b0, -1);
        check_all("missing_ctrl");
        clear_err();

        send_ctrl(16'd4, 16'd2, 3);
        send_video(7, 1'b0, -1);
        check_all("short_video");
        clear_err();

        send_ctrl(16'd4, 16'd2, 3);
        send_video(3, 1'b1, -1);
        send_ctrl(16'd8, 16'd5, 3);
        check_all("sop_mid_video");
        send_video(40, 1'b0, -1);
        check_all("after_abandon");
        clear_err();

        send_ctrl(16'd3, 16'd3, 3);
        send_video(0, 1'b0, -1);
        check_all("hdr_only_bad");
        clear_err();
        send_ctrl(16'd0, 16'd5, 3);
        send_video(0, 1'b0, -1);
        check_all("hdr_only_zero_dim");
        send_ctrl(16'd0, 16'd5, 3);
        send_video(2, 1'b0, -1);
        check_all("pixels_zero_dim");
        clear_err();

        send_skip(4'h5, 6);
        send_skip(4'h9, 0);
        send_ctrl(16'd2, 16'd2, 3);
        send_video(4, 1'b0, -1);
        check_all("skip_then_good");

        send_ctrl(16'd6, 16'd6, 5);
        send_ctrl(16'd7, 16'd7, 0);
        check_all("long_and_empty_ctrl");
        clear_err();

        m_err = 4'd0;
        err_clear = 1'b1;
        send_ctrl(16'd5, 16'd5, 1);
        err_clear = 1'b0;
        check_all("clear_vs_new_error");
        clear_err();

        for (int it = 0; it < 12; it++) begin
            int w, h, nb, n, area;
            w  = int'($urandom_range(1, 12));
            h  = int'($urandom_range(1, 6));
            nb = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 5)) : 3;
            send_ctrl(16'(w), 16'(h), nb);
            area = int'(m_w) * int'(m_h);
            case ($urandom_range(0, 3))
                0: n = area - 1;
                1: n = area + 1;
                default: n = area;
            endcase
            if (n < 0) n = 0;
            send_video(n, 1'b0, -1);
            check_all("random");
            if (m_err != 4'd0 && $urandom_range(0, 1) == 1) clear_err();
        end

        send_ctrl(16'd10, 16'd4, 3);
        send_video(15, 1'b1, -1);
        reset = 1'b1;
        err_clear = 1'b1;
        #1;
        check_zero("reset_mid_frame");
        @(posedge clock);
        #1;
        reset = 1'b0;
        err_clear = 1'b0;
        rdy_prev = 1'b0;
        m_w = 16'd0; m_h = 16'd0; m_fcnt = 16'd0; m_fg = 32'd0; m_err = 4'd0;
        m_cv = 1'b0; m_open = 1'b0;
        idle(2);
        send_ctrl(16'd4, 16'd3, 3);
        send_video(12, 1'b0, -1);
        check_all("post_reset_frame");
        check("post_reset_frame_cnt", 32'(frame_cnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
